// File: rtl/mdu_if.sv
// Bus between the E-stage pipeline and the multiply/divide sequencer.
// Handshake: start is a one-cycle valid with no ready; the pipeline holds off further MDU/MFxx work while mdu_block is high.
interface mdu_if;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        rd_sel;
  logic        busy;
  logic        mdu_block;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic [31:0] rd_data;
  logic        state_dbg;

  modport master (
    output start, mdu_op, rs_data, rt_data, rd_sel,
    input  busy, mdu_block, hi_out, lo_out, rd_data, state_dbg
  );

  modport slave (
    input  start, mdu_op, rs_data, rt_data, rd_sel,
    output busy, mdu_block, hi_out, lo_out, rd_data, state_dbg
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO; results are computed at issue and
// committed after a fixed latency so the hazard unit sees a deterministic busy window.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          busy_q;
  logic [31:0]   hi_q, lo_q, pend_hi, pend_lo;

  logic               is_md;
  logic               div_zero;
  logic signed [63:0] a64, b64, prod_s;
  logic [63:0]        prod_u;
  logic signed [32:0] a33, b33, q33, r33;
  logic [31:0]        q_u, r_u;
  logic               unused_sign;

  assign is_md    = (bus.mdu_op >= OP_MULT) && (bus.mdu_op <= OP_DIVU);
  assign div_zero = (bus.rt_data == 32'd0);

  // 33-bit signed divide keeps 0x80000000 / -1 representable, so no special case is needed.
  always_comb begin
    a64    = {{32{bus.rs_data[31]}}, bus.rs_data};
    b64    = {{32{bus.rt_data[31]}}, bus.rt_data};
    prod_s = a64 * b64;
    prod_u = {32'd0, bus.rs_data} * {32'd0, bus.rt_data};
    a33    = {bus.rs_data[31], bus.rs_data};
    b33    = {bus.rt_data[31], bus.rt_data};
    q33    = a33 / b33;
    r33    = a33 % b33;
    q_u    = bus.rs_data / bus.rt_data;
    r_u    = bus.rs_data % bus.rt_data;
  end

  assign unused_sign = q33[32] ^ r33[32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            case (bus.mdu_op)
              OP_MULT: begin
                pend_hi <= prod_s[63:32];
                pend_lo <= prod_s[31:0];
                cnt     <= MULT_N;
                busy_q  <= 1'b1;
                state   <= BUSY;
              end
              OP_MULTU: begin
                pend_hi <= prod_u[63:32];
                pend_lo <= prod_u[31:0];
                cnt     <= MULT_N;
                busy_q  <= 1'b1;
                state   <= BUSY;
              end
              OP_DIV: begin
                // Divide by zero still runs the full latency but commits HI/LO unchanged.
                pend_hi <= div_zero ? hi_q : r33[31:0];
                pend_lo <= div_zero ? lo_q : q33[31:0];
                cnt     <= DIV_N;
                busy_q  <= 1'b1;
                state   <= BUSY;
              end
              OP_DIVU: begin
                pend_hi <= div_zero ? hi_q : r_u;
                pend_lo <= div_zero ? lo_q : q_u;
                cnt     <= DIV_N;
                busy_q  <= 1'b1;
                state   <= BUSY;
              end
              OP_MTHI: hi_q <= bus.rs_data;
              OP_MTLO: lo_q <= bus.rs_data;
              default: ;
            endcase
          end
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            hi_q   <= pend_hi;
            lo_q   <= pend_lo;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.mdu_block = (bus.start & is_md) | busy_q;
  assign bus.hi_out    = hi_q;
  assign bus.lo_out    = lo_q;
  assign bus.rd_data   = bus.rd_sel ? hi_q : lo_q;
  assign bus.state_dbg = (state == BUSY);
endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed corner cases then random ops against a cycle-stamped
// behavioural model of HI/LO using 64-bit integer arithmetic.
module tb_mdu_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_if bus ();

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: architectural HI/LO, result of the op in flight and the cycle stamp it lands on.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
  bit          m_inflight = 1'b0;
  int          cyc = 0;
  int          done_at = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    m_phi = m_hi;
    m_plo = m_lo;
    case (op)
      3'd1: begin sp = sa * sb; m_phi = sp[63:32]; m_plo = sp[31:0]; end
      3'd2: begin up = ua * ub; m_phi = up[63:32]; m_plo = up[31:0]; end
      3'd3: if (b != 0) begin
        sq = sa / sb; sr = sa % sb; m_phi = sr[31:0]; m_plo = sq[31:0];
      end
      3'd4: if (b != 0) begin
        up = ua / ub; m_plo = up[31:0]; up = ua % ub; m_phi = up[31:0];
      end
      default: ;
    endcase
    m_inflight = 1'b1;
    done_at = cyc + ((op <= 3'd2) ? MC : DC);
    exp_q.push_back({m_phi, m_plo});
  endtask

  // One clock: drive inputs, check outputs at negedge, advance the model at posedge.
  task automatic step(input bit s, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input bit sel);
    bit          commit;
    logic [63:0] e;
    commit = 1'b0;
    bus.start = s; bus.mdu_op = op; bus.rs_data = a; bus.rt_data = b; bus.rd_sel = sel;
    @(negedge clk);
    chk("busy", 64'(bus.busy), 64'(m_inflight));
    chk("state_dbg", 64'(bus.state_dbg), 64'(m_inflight));
    chk("mdu_block", 64'(bus.mdu_block), 64'((s && op >= 3'd1 && op <= 3'd4) || m_inflight));
    chk("hi_out", 64'(bus.hi_out), 64'(m_hi));
    chk("lo_out", 64'(bus.lo_out), 64'(m_lo));
    chk("rd_data", 64'(bus.rd_data), 64'(sel ? m_hi : m_lo));
    @(posedge clk);
    cyc++;
    if (m_inflight) begin
      if (cyc == done_at) begin
        m_hi = m_phi; m_lo = m_plo; m_inflight = 1'b0; commit = 1'b1;
      end
    end else if (s) begin
      case (op)
        3'd1, 3'd2, 3'd3, 3'd4: model_issue(op, a, b);
        3'd5: m_hi = a;
        3'd6: m_lo = a;
        default: ;
      endcase
    end
    #1;
    if (commit) begin
      if (exp_q.size() == 0) chk("commit_q_empty", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("commit_hilo", {bus.hi_out, bus.lo_out}, e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, $urandom, $urandom, 1'($urandom_range(0, 1)));
  endtask

  task automatic pulse_reset();
    bus.start = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_hi", 64'(bus.hi_out), 64'd0);
    chk("rst_lo", 64'(bus.lo_out), 64'd0);
    m_hi = 32'd0; m_lo = 32'd0; m_phi = 32'd0; m_plo = 32'd0; m_inflight = 1'b0;
    exp_q.delete();
    @(posedge clk);
    cyc++;
    #2 reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] sp[5];
    sp[0] = 32'd0; sp[1] = 32'd1; sp[2] = 32'hFFFF_FFFF; sp[3] = 32'h8000_0000; sp[4] = 32'd7;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    reset = 1'b0;
    bus.start = 1'b0; bus.mdu_op = 3'd0; bus.rs_data = 32'd0; bus.rt_data = 32'd0; bus.rd_sel = 1'b0;
    #3;
    chk("init_busy", 64'(bus.busy), 64'd0);
    chk("init_block", 64'(bus.mdu_block), 64'd0);
    chk("init_hi", 64'(bus.hi_out), 64'd0);
    chk("init_lo", 64'(bus.lo_out), 64'd0);
    @(posedge clk); cyc++;
    @(posedge clk); cyc++;
    #2 reset = 1'b1;

    step(1'b1, 3'd1, 32'hFFFF_FFFD, 32'd7, 1'b1);
    idle(MC + 1);
    chk("mult_hi", 64'(bus.hi_out), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(bus.lo_out), 64'hFFFF_FFEB);

    step(1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    idle(MC + 1);
    chk("multu_hi", 64'(bus.hi_out), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(bus.lo_out), 64'h0000_0001);

    step(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(DC + 1);
    chk("div_hi", 64'(bus.hi_out), 64'hFFFF_FFFF);
    chk("div_lo", 64'(bus.lo_out), 64'hFFFF_FFFD);

    step(1'b1, 3'd4, 32'd100, 32'd7, 1'b1);
    idle(DC + 1);
    chk("divu_hi", 64'(bus.hi_out), 64'd2);
    chk("divu_lo", 64'(bus.lo_out), 64'd14);

    step(1'b1, 3'd5, 32'h1234, 32'd0, 1'b1);
    step(1'b1, 3'd4, 32'hDEAD_BEEF, 32'd0, 1'b1);
    idle(DC + 1);
    chk("div0_hi", 64'(bus.hi_out), 64'h1234);
    chk("div0_lo", 64'(bus.lo_out), 64'd14);

    step(1'b1, 3'd1, 32'd3, 32'd5, 1'b0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 3'd6, 32'hAAAA, 32'd0, 1'b0);
    idle(MC);
    chk("mtlo_ign_lo", 64'(bus.lo_out), 64'd15);
    chk("mtlo_ign_hi", 64'(bus.hi_out), 64'd0);

    step(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(DC + 1);
    chk("divovf_lo", 64'(bus.lo_out), 64'h8000_0000);
    chk("divovf_hi", 64'(bus.hi_out), 64'd0);

    step(1'b1, 3'd5, 32'h5555, 32'd0, 1'b1);
    step(1'b1, 3'd3, 32'd1000, 32'd3, 1'b0);
    idle(3);
    pulse_reset();
    idle(DC + 2);

    for (int i = 0; i < 2500; i++)
      step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
           1'($urandom_range(0, 1)));
    idle(DC + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
